// File: rtl/m_fetch_buf_pkg.sv
// Shared types and constants for the IF stage: NOP encoding, reset PC,
// MIPS primary opcodes and the {pc, ir} queue entry.
package m_fetch_buf_pkg;

    localparam logic [31:0] NOP          = 32'h0000_0020;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_REGIMM  = 6'h01,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_ADDIU   = 6'h09,
        OP_LW      = 6'h23,
        OP_SW      = 6'h2b
    } opcode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Prefetch queue of {pc, ir} entries. Flush wins over push and pop; a pop on
// an empty queue is ignored.
module m_fetch_fifo
    import m_fetch_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [63:0]   push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output logic [63:0]   head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which
    // entries are meaningful, so clearing the data would only cost logic.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/m_fetch_buf.sv
// IF stage: issues sequential imem fetches, tags returned words with their
// PC, queues them and presents the head to ID with a valid/ready handshake.
module m_fetch_buf
    import m_fetch_buf_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 12,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    output logic [AW-1:0] w_imem_addr,
    input  logic [31:0]   w_imem_rdata,
    input  logic          w_redirect,
    input  logic [31:0]   w_redirect_pc,
    input  logic          w_halt,
    output logic          r_valid,
    output logic [31:0]   r_ir,
    output logic [31:0]   r_pc,
    output logic [31:0]   w_pc4,
    input  logic          w_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   ifpc_q, ifpc_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count;
    logic [63:0]   head_raw;
    fetch_entry_t  head;
    logic          pop;
    logic          push;
    logic          issue;

    assign pop  = r_valid & w_ready;
    assign push = inflight_q & ~w_redirect;

    // The in-flight word is counted as occupied, so its push always has room.
    assign issue = ~w_halt & ~w_redirect &
                   ((OW'(count) + OW'(inflight_q)) < (OW'(DEPTH) + OW'(pop)));

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        fpc_d      = fpc_q;
        ifpc_d     = ifpc_q;
        inflight_d = 1'b0;
        if (w_redirect) begin
            fpc_d = w_redirect_pc;
        end else if (issue) begin
            inflight_d = 1'b1;
            ifpc_d     = fpc_q;
            fpc_d      = pc_next(fpc_q);
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            fpc_q      <= RESET_PC;
            ifpc_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            ifpc_q     <= ifpc_d;
            inflight_q <= inflight_d;
        end
    end

    m_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (w_clk),
        .rst_n_i     (w_rst_n),
        .push_i      (push),
        .push_data_i ({ifpc_q, w_imem_rdata}),
        .pop_i       (pop),
        .flush_i     (w_redirect),
        .count_o     (count),
        .head_o      (head_raw)
    );

    assign head        = head_raw;
    assign r_valid     = (count != '0);
    assign r_pc        = r_valid ? head.pc : 32'h0;
    assign r_ir        = r_valid ? head.ir : NOP;
    assign w_pc4       = pc_next(r_pc);
    assign w_imem_addr = fpc_q[AW+1:2];

endmodule

// File: tb/tb_m_fetch_buf.sv
// Bench for m_fetch_buf: cycle-exact directed scenarios plus a randomized
// run against a PC-stream reference model.
module tb_m_fetch_buf;

    localparam int          DEPTH  = 4;
    localparam int          AW     = 12;
    localparam logic [31:0] NOP_IR = 32'h0000_0020;

    logic          w_clk;
    logic          w_rst_n;
    logic [AW-1:0] w_imem_addr;
    logic [31:0]   w_imem_rdata;
    logic          w_redirect;
    logic [31:0]   w_redirect_pc;
    logic          w_halt;
    logic          r_valid;
    logic [31:0]   r_ir;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc4;
    logic          w_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    m_fetch_buf #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .RESET_PC (32'h0)
    ) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_imem_addr   (w_imem_addr),
        .w_imem_rdata  (w_imem_rdata),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc),
        .w_halt        (w_halt),
        .r_valid       (r_valid),
        .r_ir          (r_ir),
        .r_pc          (r_pc),
        .w_pc4         (w_pc4),
        .w_ready       (w_ready)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Instruction memory with one-cycle synchronous read
    always @(posedge w_clk) w_imem_rdata <= mem[w_imem_addr];

    task automatic cyc();
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        w_rst_n       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        w_halt        = 1'b0;
        w_ready       = 1'b0;
        repeat (2) cyc();
        w_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [127:0] got, exp;
        do_reset();
        w_ready = 1'b1;
        got = {r_valid, r_pc, r_ir, w_pc4, w_imem_addr};
        exp = {1'b0, 32'h0, NOP_IR, 32'h4, 12'h0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_values: got %h expected %h", got, exp); end
        cyc();
        got = {r_valid, w_imem_addr};
        exp = {1'b0, 12'd1};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_first_issue: got %h expected %h", got, exp); end
        cyc();
        got = {r_valid, r_pc, r_ir, w_pc4};
        exp = {1'b1, 32'h0, 32'h0, 32'h4};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_first_word: got %h expected %h", got, exp); end
    endtask

    // Continues from test_reset: one new word per cycle while ID pops
    task automatic test_back_to_back();
        logic [127:0] got, exp;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            got = {r_valid, r_pc, r_ir, w_pc4};
            exp = {1'b1, 32'(4 * i), 32'(i), 32'(4 * i + 4)};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_fill();
        logic [127:0] got, exp;
        do_reset();
        repeat (7) cyc();
        got = {r_valid, r_pc, r_ir, w_imem_addr};
        exp = {1'b1, 32'h0, 32'h0, 12'd4};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL fill_full: got %h expected %h", got, exp); end
        cyc();
        got = {r_valid, w_imem_addr};
        exp = {1'b1, 12'd4};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL fill_addr_hold: got %h expected %h", got, exp); end
        w_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            got = {r_valid, r_pc, r_ir};
            exp = {1'b1, 32'(4 * i), 32'(i)};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL fill_drain[%0d]: got %h expected %h", i, got, exp); end
            cyc();
        end
    endtask

    task automatic test_redirect_inflight();
        logic [127:0] got, exp;
        do_reset();
        w_ready = 1'b1;
        repeat (4) cyc();
        w_ready = 1'b0;
        cyc();
        // Queue holds 8,12 and the fetch of 16 is in flight
        got = {r_valid, r_pc, w_imem_addr};
        exp = {1'b1, 32'h8, 12'd5};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL redir_setup: got %h expected %h", got, exp); end
        w_redirect    = 1'b1;
        w_redirect_pc = 32'h40;
        cyc();
        w_redirect = 1'b0;
        w_ready    = 1'b1;
        got = {r_valid, r_pc, r_ir, w_imem_addr};
        exp = {1'b0, 32'h0, NOP_IR, 12'h10};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL redir_flush: got %h expected %h", got, exp); end
        cyc();
        got = {r_valid, w_imem_addr};
        exp = {1'b0, 12'h11};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL redir_no_stale: got %h expected %h", got, exp); end
        cyc();
        got = {r_valid, r_pc, r_ir};
        exp = {1'b1, 32'h40, 32'h10};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL redir_target: got %h expected %h", got, exp); end
        cyc();
        got = {r_valid, r_pc, r_ir};
        exp = {1'b1, 32'h44, 32'h11};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL redir_target_next: got %h expected %h", got, exp); end
    endtask

    task automatic test_redirect_pop();
        logic [127:0] got, exp;
        do_reset();
        w_ready = 1'b1;
        repeat (4) cyc();
        got = {r_valid, r_pc};
        exp = {1'b1, 32'h8};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rpop_setup: got %h expected %h", got, exp); end
        w_redirect    = 1'b1;
        w_redirect_pc = 32'h80;
        cyc();
        w_redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            got = {r_valid, r_pc, r_ir};
            exp = {1'b0, 32'h0, NOP_IR};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL rpop_empty[%0d]: got %h expected %h", i, got, exp); end
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            got = {r_valid, r_pc, r_ir};
            exp = {1'b1, 32'(32'h80 + 4 * i), 32'(32'h20 + i)};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL rpop_target[%0d]: got %h expected %h", i, got, exp); end
            cyc();
        end
    endtask

    task automatic test_halt();
        logic [127:0] got, exp;
        do_reset();
        repeat (3) cyc();
        // Words 0,4 queued and the fetch of 8 in flight
        got = {r_valid, r_pc, w_imem_addr};
        exp = {1'b1, 32'h0, 12'd3};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL halt_setup: got %h expected %h", got, exp); end
        w_halt  = 1'b1;
        w_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            cyc();
            got = {r_valid, r_pc, r_ir};
            exp = {1'b1, 32'(4 * i), 32'(i)};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL halt_drain[%0d]: got %h expected %h", i, got, exp); end
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            got = {r_valid, r_pc, r_ir, w_imem_addr};
            exp = {1'b0, 32'h0, NOP_IR, 12'd3};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL halt_idle[%0d]: got %h expected %h", i, got, exp); end
        end
        w_halt = 1'b0;
        cyc();
        got = {r_valid, w_imem_addr};
        exp = {1'b0, 12'd4};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL halt_resume_issue: got %h expected %h", got, exp); end
        cyc();
        got = {r_valid, r_pc, r_ir};
        exp = {1'b1, 32'hc, 32'h3};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL halt_resume_word: got %h expected %h", got, exp); end
    endtask

    task automatic test_pc_wrap();
        logic [127:0] got, exp;
        logic [31:0]  pcs [3];
        logic [31:0]  irs [3];
        pcs = '{32'hffff_fff8, 32'hffff_fffc, 32'h0};
        irs = '{32'hffe, 32'hfff, 32'h0};
        do_reset();
        w_ready       = 1'b1;
        w_redirect    = 1'b1;
        w_redirect_pc = 32'hffff_fff8;
        cyc();
        w_redirect = 1'b0;
        got = {r_valid, w_imem_addr};
        exp = {1'b0, 12'hffe};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL wrap_addr: got %h expected %h", got, exp); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            got = {r_valid, r_pc, r_ir, w_pc4};
            exp = {1'b1, pcs[i], irs[i], pcs[i] + 32'd4};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL wrap_word[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [127:0] got, exp;
        do_reset();
        w_ready = 1'b1;
        repeat (5) cyc();
        got = {r_valid, r_pc};
        exp = {1'b1, 32'hc};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL mid_setup: got %h expected %h", got, exp); end
        #3;
        w_rst_n = 1'b0;
        #1;
        got = {r_valid, r_pc, r_ir, w_pc4, w_imem_addr};
        exp = {1'b0, 32'h0, NOP_IR, 32'h4, 12'h0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL mid_async_reset: got %h expected %h", got, exp); end
        cyc();
        w_rst_n = 1'b1;
        cyc();
        got = {r_valid, w_imem_addr};
        exp = {1'b0, 12'd1};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL mid_restart_issue: got %h expected %h", got, exp); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            got = {r_valid, r_pc, r_ir};
            exp = {1'b1, 32'(4 * i), 32'(i)};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL mid_restart_word[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    // Reference: ID must see the sequential PC stream, restarting at each
    // redirect target, with ir = mem[pc]; nothing is visible right after a
    // redirect, and the queue never starves for long while not halted.
    task automatic test_random();
        logic [127:0] got, exp;
        logic [31:0]  exp_pc;
        logic [31:0]  tgt;
        bit           expect_empty;
        int           starve;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        do_reset();
        w_ready      = 1'b1;
        exp_pc       = 32'h0;
        expect_empty = 1'b0;
        starve       = 0;
        for (int n = 0; n < 3000; n++) begin
            if (expect_empty) begin
                checks++;
                if (r_valid !== 1'b0) begin failures++; $display("FAIL rand_flush[%0d]: got valid=%b expected valid=0", n, r_valid); end
            end
            if (r_valid !== 1'b1) begin
                got = {r_valid, r_pc, r_ir, w_pc4};
                exp = {1'b0, 32'h0, NOP_IR, 32'h4};
                checks++;
                if (got !== exp) begin failures++; $display("FAIL rand_idle[%0d]: got %h expected %h", n, got, exp); end
            end else begin
                got = {r_pc, r_ir, w_pc4};
                exp = {exp_pc, mem[exp_pc[AW+1:2]], exp_pc + 32'd4};
                checks++;
                if (got !== exp) begin failures++; $display("FAIL rand_head[%0d]: got %h expected %h", n, got, exp); end
            end
            if (r_valid === 1'b1 || w_halt) starve = 0;
            else starve++;
            checks++;
            if (starve > 3) begin failures++; $display("FAIL rand_starve[%0d]: got %0d empty cycles expected at most 3", n, starve); end

            w_ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) w_halt = ~w_halt;
            if (!w_redirect && $urandom_range(19) == 0) begin
                tgt = $urandom & 32'hffff_fffc;
                if ($urandom_range(3) == 0) tgt = 32'hffff_fff0 | (tgt & 32'hc);
                w_redirect    = 1'b1;
                w_redirect_pc = tgt;
                exp_pc        = tgt;
                expect_empty  = 1'b1;
                starve        = 0;
            end else begin
                w_redirect   = 1'b0;
                expect_empty = 1'b0;
                if (r_valid === 1'b1 && w_ready) exp_pc = exp_pc + 32'd4;
            end
            cyc();
        end
        w_redirect = 1'b0;
        w_halt     = 1'b0;
    endtask

    initial begin
        w_rst_n       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        w_halt        = 1'b0;
        w_ready       = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i);
        test_reset();
        test_back_to_back();
        test_fill();
        test_redirect_inflight();
        test_redirect_pop();
        test_halt();
        test_pc_wrap();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
